// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-client RAM arbiter: FSM states and RWS polarity.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic RWS_READ  = 1'b0;
    localparam logic RWS_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: contention goes to the pointer client,
// a lone request wins regardless of the pointer.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       valid_o,
    output logic       gnt_o
);

    always_comb begin
        valid_o = |req_i;
        gnt_o   = (req_i == 2'b11) ? ptr_i : req_i[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for the 1K x 8 tristate-bus RAM.
// Optional per-client grant counters are enabled by defining RAM_ARB_GRANT_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; winner's addr/we/wdata/id latched on exit
// SETUP  | RAM selected, address/RWS driven, bus driven for writes
// ACCESS | outputs held; read data captured at cycle end
// RESP   | RAM deselected, ack pulsed to the winner, pointer flips
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
`ifdef RAM_ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_rws,
    output logic              ram_cs,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]  gcnt0,
    output logic [CNT_W-1:0]  gcnt1
`endif
);

    arb_state_e        state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_valid;
    logic              gnt_id;

    rr_pick2 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (gnt_valid),
        .gnt_o   (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            we_q    <= RWS_READ;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = we[gnt_id];
                    addr_d  = gnt_id ? addr1 : addr0;
                    wdata_d = gnt_id ? wdata1 : wdata0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                rdata_d = (we_q == RWS_READ) ? ram_rdata : '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ptr_d   = ~id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address, RWS and write data simply hold the latched copy; cs/en/oe gate the RAM.
    always_comb begin
        ack       = 2'b00;
        busy      = (state_q != ST_IDLE);
        ram_en    = 1'b0;
        ram_cs    = 1'b0;
        ram_oe    = 1'b0;
        ram_addr  = addr_q;
        ram_rws   = we_q;
        ram_wdata = wdata_q;
        rdata     = rdata_q;
        case (state_q)
            ST_SETUP, ST_ACCESS: begin
                ram_en = 1'b1;
                ram_cs = 1'b1;
                ram_oe = (we_q == RWS_WRITE);
            end
            ST_RESP:  ack = id_q ? 2'b10 : 2'b01;
            default:  ack = 2'b00;
        endcase
    end

`ifdef RAM_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gcnt0_q, gcnt1_q;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (!id_q && gcnt0_q != '1) gcnt0_q <= gcnt0_q + CNT_ONE;
            if (id_q && gcnt1_q != '1)  gcnt1_q <= gcnt1_q + CNT_ONE;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1K x 8 RAM beside it.
// Grant-counter checks run only when RAM_ARB_GRANT_CNT_EN is defined.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, we, ack;
    logic [9:0] addr0, addr1, ram_addr;
    logic [7:0] wdata0, wdata1, rdata, ram_wdata, ram_rdata;
    logic       busy, ram_en, ram_rws, ram_cs, ram_oe;
`ifdef RAM_ARB_GRANT_CNT_EN
    logic [1:0] gcnt0, gcnt1;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

`ifdef RAM_ARB_GRANT_CNT_EN
    ram_arbiter #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_rws   (ram_rws),
        .ram_cs    (ram_cs),
        .ram_wdata (ram_wdata),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata),
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
    );
`else
    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_rws   (ram_rws),
        .ram_cs    (ram_cs),
        .ram_wdata (ram_wdata),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata)
    );
`endif

    // RAM model: synchronous write while selected in write mode, asynchronous read.
    always @(posedge clk)
        if (ram_cs && ram_en && ram_rws) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = (ram_cs && ram_en && !ram_rws) ? mem[ram_addr] : 8'hFF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        req = 2'b00;
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    // One access from client c starting in a fresh IDLE cycle; ack expected 3 cycles later.
    task automatic do_access(input int c, input logic w, input logic [9:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle"}, busy, 1'b0);
        req[c] = 1'b1;
        we[c]  = w;
        if (c == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin
                chk({tag, "_cs"},  ram_cs, 1'b1);
                chk({tag, "_oe"},  ram_oe, w);
                chk({tag, "_ack0"}, ack, 2'b00);
                if (k == 1) chk({tag, "_addr"}, ram_addr, a);
            end else begin
                chk({tag, "_ack"},  ack, (c == 1) ? 2'b10 : 2'b01);
                chk({tag, "_oeoff"}, {ram_cs, ram_oe}, 2'b00);
                chk({tag, "_rdata"}, rdata, w ? 8'h00 : exp_rd);
            end
        end
        req[c] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // 1: reset values, then idle with no requests
        #3;
        chk("rst_ack", ack, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ctl", {busy, ram_en, ram_rws, ram_cs, ram_oe}, 5'b0);
        chk("rst_addr", ram_addr, 10'h000);
        chk("rst_wdata", ram_wdata, 8'h00);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("idle_busy_cs", {busy, ram_cs}, 2'b00);
        end

        // 2: top-address write then read back by client 0
        do_access(0, 1'b1, 10'h3FF, 8'hA5, 8'h00, "t2w");
        do_access(0, 1'b0, 10'h3FF, 8'h00, 8'hA5, "t2r");

        // 3: continuous contention, strict alternation from client 0
        do_reset();
        @(posedge clk); #1;
        we = 2'b11; req = 2'b11;
        addr0 = 10'h010; wdata0 = 8'h11;
        addr1 = 10'h020; wdata1 = 8'h21;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk); #1;
            chk("rr_ack", ack, (cyc % 4 != 3) ? 2'b00 : (((cyc / 4) % 2 == 0) ? 2'b01 : 2'b10));
            if (ack[0]) begin
                if (addr0 == 10'h010) begin addr0 = 10'h011; wdata0 = 8'h12; end
                else req[0] = 1'b0;
            end
            if (ack[1]) begin
                if (addr1 == 10'h020) begin addr1 = 10'h021; wdata1 = 8'h22; end
                else req[1] = 1'b0;
            end
        end
        chk("rr_mem010", mem[10'h010], 8'h11);
        chk("rr_mem011", mem[10'h011], 8'h12);
        chk("rr_mem020", mem[10'h020], 8'h21);
        chk("rr_mem021", mem[10'h021], 8'h22);

        // 4: address 0 written by client 1, read by client 0
        do_access(1, 1'b1, 10'h000, 8'h3C, 8'h00, "t4w");
        do_access(0, 1'b0, 10'h000, 8'h00, 8'h3C, "t4r");

        // 5: reset mid-write aborts; pointer returns to client 0
        @(posedge clk); #1;
        req = 2'b01; we = 2'b01; addr0 = 10'h055; wdata0 = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_access", {ram_cs, ram_oe}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_drop", {ram_cs, ram_en, ram_oe, busy}, 4'b0000);
        @(posedge clk); #1;
        chk("t5_noack", ack, 2'b00);
        req = 2'b00;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; addr0 = 10'h3FF; addr1 = 10'h000;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        chk("t5_grant0", ack, 2'b01);
        chk("t5_rd0", rdata, 8'hA5);
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) @(posedge clk);
        #1;
        chk("t5_grant1", ack, 2'b10);
        chk("t5_rd1", rdata, 8'h3C);
        req = 2'b00;

`ifdef RAM_ARB_GRANT_CNT_EN
        // 6: client-1 grant counter saturates at all-ones
        do_reset();
        #1;
        chk("t6_cnt_rst", {gcnt0, gcnt1}, 4'h0);
        for (int i = 0; i < 5; i++)
            do_access(1, 1'b1, 10'h100 + 10'(i), 8'(i), 8'h00, "t6");
        @(posedge clk); #1;
        chk("t6_gcnt1", gcnt1, 2'd3);
        chk("t6_gcnt0", gcnt0, 2'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
